// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential word fetches over a req/ack bus, DEPTH-entry PC-tagged buffer.
// Define IPQ_BYPASS_EN to let an acknowledged word reach the core in the same cycle when the queue is empty.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CK_REF,
    input  logic        RST_N,
    input  logic        HALT,
    input  logic        FLUSH,
    input  logic [31:0] FLUSH_ADDR,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic        INST_VALID,
    output logic [31:0] INST_DATA,
    output logic [31:0] INST_PC,
    input  logic        INST_READY
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

`ifdef IPQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } state_t;

    state_t          state;
    logic [31:0]     fetch_pc;
    logic [31:0]     imem_addr_q;
    logic            imem_req_q;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     mem_data [DEPTH];
    logic [31:0]     mem_pc   [DEPTH];

    logic            head_valid;
    logic            ack_live;
    logic            bypass_hit;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count_next;
    logic [31:0]     fetch_pc_next;
    logic            issue_ok;

    // Only an ACK in REQ carries a live word; an ACK in DISCARD belongs to a flushed stream.
    always_comb begin
        head_valid = (count != '0);
        ack_live   = (state == S_REQ) && IMEM_ACK;
        bypass_hit = BYPASS && (count == '0) && ack_live && !FLUSH;
        pop        = head_valid && !HALT && INST_READY;
        push       = ack_live && !FLUSH && !(bypass_hit && !HALT && INST_READY);

        if (FLUSH) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end

        if (FLUSH) begin
            fetch_pc_next = FLUSH_ADDR & 32'hFFFF_FFFC;
        end else if (ack_live) begin
            fetch_pc_next = fetch_pc + 32'd4;
        end else begin
            fetch_pc_next = fetch_pc;
        end

        // The request about to issue becomes in flight, so the occupancy after this edge must leave room for it.
        issue_ok = !HALT && (count_next < CW'(DEPTH));
    end

    assign INST_VALID = (head_valid || bypass_hit) && !HALT;
    assign INST_DATA  = bypass_hit ? IMEM_RDATA : mem_data[rd_ptr];
    assign INST_PC    = bypass_hit ? fetch_pc   : mem_pc[rd_ptr];
    assign IMEM_REQ   = imem_req_q;
    assign IMEM_ADDR  = imem_addr_q;

    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_data[i] <= '0;
                mem_pc[i]   <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= IMEM_RDATA;
                mem_pc[wr_ptr]   <= fetch_pc;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            // A pop in the flush cycle is already consumed by the core; snapping rd_ptr covers it.
            if (FLUSH) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            fetch_pc    <= RESET_PC;
        end else begin
            fetch_pc <= fetch_pc_next;
            case (state)
                S_IDLE: begin
                    if (issue_ok) begin
                        state       <= S_REQ;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= fetch_pc_next;
                    end
                end
                S_REQ: begin
                    if (IMEM_ACK) begin
                        if (issue_ok) begin
                            imem_addr_q <= fetch_pc_next;
                        end else begin
                            state      <= S_IDLE;
                            imem_req_q <= 1'b0;
                        end
                    end else if (FLUSH) begin
                        // The bus has no abort, so the stale request rides out to its ACK.
                        state <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (IMEM_ACK) begin
                        state      <= S_IDLE;
                        imem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_prefetch_queue.md
# inst_prefetch_queue

Instruction prefetch queue for the RISC-V core, sitting between instruction memory and the fetch/decode stage. It issues sequential word fetches over a request/acknowledge memory handshake and buffers up to DEPTH instructions, each tagged with its PC. It hands instructions to the core over a valid/ready interface. Jumps and branches redirect it through a one-cycle FLUSH that discards all buffered and in-flight instructions.

## Interface
- DEPTH, 4: number of queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset; word aligned.

- CK_REF  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- HALT  in  1  freezes the pipeline: no new requests, no pops.
- FLUSH  in  1  one-cycle redirect pulse.
- FLUSH_ADDR  in  32  new fetch address; bits [1:0] are ignored and forced to 0.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  32  fetch address; stable while IMEM_REQ is high.
- IMEM_ACK  in  1  memory accepts the request and returns data in the same cycle.
- IMEM_RDATA  in  32  instruction word; sampled only when IMEM_ACK is high.
- INST_VALID  out  1  head entry is available.
- INST_DATA  out  32  head instruction.
- INST_PC  out  32  PC of the head instruction.
- INST_READY  in  1  core consumes the head entry.

## Operation
- State machine: IDLE → REQ → IDLE. From REQ, a FLUSH without ACK moves to DISCARD; DISCARD → IDLE on ACK.
- Internal registers: fetch_pc, rd_ptr, wr_ptr, count, and the in-flight flag (state is REQ or DISCARD).
- Issue rule: IMEM_REQ rises when !HALT && count + inflight < DEPTH. While HALT is high, any request already in flight stays high until it is acknowledged.
- IMEM_REQ must not deassert and IMEM_ADDR must not change before IMEM_ACK. There is no abort.
- Push on ACK in state REQ:
  - The entry {fetch_pc, IMEM_RDATA} is written at wr_ptr.
  - fetch_pc += 4, wrapping from 32'hFFFF_FFFC to 0.
  - If the issue rule still holds, IMEM_REQ stays high and the next cycle carries the new address (back-to-back fetches).
- Pop: INST_VALID = (count != 0) && !HALT. A pop occurs when INST_VALID && INST_READY; rd_ptr advances.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- FLUSH has priority over push. In the cycle after a FLUSH:
  - count = 0, rd_ptr = wr_ptr.
  - fetch_pc = {FLUSH_ADDR[31:2], 2'b00}.
  - A pop in the FLUSH cycle is still honoured, because the core took that entry.
- FLUSH with IMEM_ACK in the same cycle: the returning data is dropped, there is no DISCARD state, and the new request can issue the next cycle.
- FLUSH while a request is in flight without ACK: go to DISCARD. REQ stays high at the old address until ACK, the data is dropped, and the request to the new address issues the following cycle.
- A second FLUSH while in DISCARD updates fetch_pc only.
- FLUSH during HALT takes effect normally; requests resume when HALT drops.

## Timing
- Reset values:
  - IMEM_REQ = 0, IMEM_ADDR = RESET_PC, INST_VALID = 0.
  - INST_DATA = 0 and INST_PC = 0, because all storage resets to 0.
  - fetch_pc = RESET_PC, count = 0, state = IDLE.
- Reset asserted mid-transaction clears everything immediately. The outstanding memory access is abandoned.
- IMEM_REQ is first asserted in the first rising edge after RST_N deasserts.
- Latency from ACK to INST_VALID is 1 cycle (without bypass).
- Zero-wait memory sustains one instruction per cycle.
- INST_VALID, INST_DATA and INST_PC are combinational from the head entry plus HALT. IMEM_REQ and IMEM_ADDR are registered.

## Configuration
- IPQ_BYPASS_EN defined:
  - When count == 0, state is REQ, IMEM_ACK is high and FLUSH is low, INST_VALID is asserted in the same cycle (subject to HALT), with INST_DATA = IMEM_RDATA and INST_PC = fetch_pc.
  - If INST_READY is also high, the word is consumed and not written to the queue; otherwise it is pushed normally.
  - ACK-to-valid latency is 0.
- IPQ_BYPASS_EN undefined: no bypass path; latency is always 1 cycle.

## Test plan
- Reset release with RESET_PC = 0, memory acks every cycle, INST_READY = 1 → addresses 0, 4, 8, 12 are requested on consecutive cycles. INST_PC follows one cycle behind (zero cycles behind with IPQ_BYPASS_EN).
- INST_READY = 0 with DEPTH = 4 → exactly 4 acknowledged fetches (0x0–0xC), then IMEM_REQ = 0. After one pop, a request for 0x10 issues.
- Memory acks 3 cycles late and FLUSH (FLUSH_ADDR = 0x103) is pulsed in the second wait cycle → IMEM_ADDR stays at the old address until ACK, that data never appears on INST_VALID, and the next request goes to 0x100.
- FLUSH with ACK in the same cycle and FLUSH_ADDR = 0x200 → the queue is empty the next cycle and the next IMEM_ADDR is 0x200 with no DISCARD cycle.
- HALT raised with 2 entries queued and a request in flight → INST_VALID = 0, the in-flight ACK is stored (count = 3), and no new REQ issues. On HALT release, the entries pop in order.
- fetch_pc = 0xFFFF_FFFC after a FLUSH → the following request address is 0x0000_0000. Pointer wrap is verified across more than 2×DEPTH pushes and pops.
